// File: rtl/serial_7seg_pkg.sv
// serial_7seg_pkg: segment patterns, digit codes and FSM encoding for the 7-seg serial receiver.
package serial_7seg_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] DIGIT_BLANK   = 4'hF;
  localparam logic [3:0] DIGIT_INVALID = 4'hE;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
endpackage

// File: rtl/serial_7seg_receiver_seg7_to_bcd.sv
// seg7_to_bcd: maps a 7-bit active-high segment pattern to a BCD digit; unknown patterns flag err_o.
module seg7_to_bcd
  import serial_7seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       err_o,
  output logic [3:0] bcd_o
);
  always_comb begin
    bcd_o = DIGIT_INVALID;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: bcd_o = DIGIT_BLANK;
      default:   bcd_o = DIGIT_INVALID;
    endcase
    err_o = (bcd_o == DIGIT_INVALID);
  end
endmodule

// File: rtl/serial_7seg_receiver.sv
// serial_7seg_receiver: captures 3-wire shift-out frames of 7-seg bytes and latches them on the latch edge.
// Optional BCD decode of each latched byte is enabled by defining SERIAL_7SEG_RX_DECODE_EN.
module serial_7seg_receiver
  import serial_7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SYNC_STAGES    = 2,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_en,
  input  logic                    i_serial_data,
  input  logic                    i_serial_clk,
  input  logic                    i_serial_latch,
  output logic [8*NUM_DIGITS-1:0] o_segments,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic [NUM_DIGITS-1:0]   o_decode_err,
  output logic                    o_frame_stb,
  output logic                    o_frame_err,
  output logic                    o_busy
);
  localparam int FRAME_BITS = 8 * NUM_DIGITS;
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_BITS + 1);
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [1:0] prev_q;
  logic [2:0] sync_w;
  logic clk_rise, latch_rise, bit_in, frame_ok;
  logic [FRAME_BITS-1:0] shift_q, shift_d, seg_q, seg_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [0:0] state_q, state_d;
  logic stb_q, err_q;
  assign sync_w     = sync_q[SYNC_STAGES-1];
  assign clk_rise   = i_en & sync_w[1] & ~prev_q[0];
  assign latch_rise = i_en & sync_w[2] & ~prev_q[1];
  assign bit_in     = sync_w[0] ^ (SEG_ACTIVE_LOW != 0);
  // a clk edge coincident with the latch edge is shifted and counted before the frame is judged
  always_comb begin
    shift_d  = clk_rise ? {shift_q[FRAME_BITS-2:0], bit_in} : shift_q;
    cnt_inc  = (clk_rise && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    cnt_d    = latch_rise ? '0 : cnt_inc;
    state_d  = latch_rise ? ST_IDLE : clk_rise ? ST_SHIFT : state_q;
    frame_ok = latch_rise && cnt_inc == FRAME_CNT;
    seg_d    = frame_ok ? shift_d : seg_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      seg_q   <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], {i_serial_latch, i_serial_clk, i_serial_data}};
      prev_q  <= sync_w[2:1];
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      stb_q   <= frame_ok;
      err_q   <= latch_rise && !frame_ok;
    end
  end
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dp
    assign o_dp[g] = seg_q[8*g+7];
  end
  assign o_segments  = seg_q;
  assign o_frame_stb = stb_q;
  assign o_frame_err = err_q;
  assign o_busy      = (state_q == ST_SHIFT);
`ifdef SERIAL_7SEG_RX_DECODE_EN
  logic [4*NUM_DIGITS-1:0] bcd_w, digits_q;
  logic [NUM_DIGITS-1:0] derr_w, derr_q;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_to_bcd u_dec (
      .seg_i (shift_d[8*g +: 7]),
      .err_o (derr_w[g]),
      .bcd_o (bcd_w[4*g +: 4])
    );
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      digits_q <= {NUM_DIGITS{DIGIT_BLANK}};
      derr_q   <= '0;
    end else if (frame_ok) begin
      digits_q <= bcd_w;
      derr_q   <= derr_w;
    end
  end
  assign o_digits     = digits_q;
  assign o_decode_err = derr_q;
`else
  assign o_digits     = {NUM_DIGITS{DIGIT_BLANK}};
  assign o_decode_err = '0;
`endif
endmodule

// File: tb/tb_serial_7seg_receiver.sv
// tb_serial_7seg_receiver: table-driven frame vectors plus reset, enable and coincident-edge sequences.
module tb_serial_7seg_receiver;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, sdata = 1'b0, sclk = 1'b0, slatch = 1'b0;
  logic [47:0] seg, seg_n;
  logic [23:0] dig, dig_n;
  logic [5:0] dp, dp_n, derr, derr_n;
  logic stb, ferr, busy, stb_i, ferr_i, busy_n;
  int checks = 0, failures = 0;
  int stb_cnt = 0, ferr_cnt = 0, stb_cnt_n = 0;

  always #5 clk = ~clk;

  serial_7seg_receiver dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_serial_data(sdata),
    .i_serial_clk(sclk), .i_serial_latch(slatch), .o_segments(seg), .o_digits(dig),
    .o_dp(dp), .o_decode_err(derr), .o_frame_stb(stb), .o_frame_err(ferr), .o_busy(busy)
  );

  serial_7seg_receiver #(.SEG_ACTIVE_LOW(1)) dut_n (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_serial_data(~sdata),
    .i_serial_clk(sclk), .i_serial_latch(slatch), .o_segments(seg_n), .o_digits(dig_n),
    .o_dp(dp_n), .o_decode_err(derr_n), .o_frame_stb(stb_i), .o_frame_err(ferr_i), .o_busy(busy_n)
  );

  always @(posedge clk) begin
    if (stb) stb_cnt++;
    if (ferr) ferr_cnt++;
    if (stb_i) stb_cnt_n++;
  end

  typedef struct {
    logic [47:0] frame;
    int          nbits;
    int          stb;
    int          err;
    logic [47:0] seg;
    logic [23:0] dig;
    logic [5:0]  dp;
    logic [5:0]  derr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sdata = b;
    repeat (6) @(posedge clk);
    sclk = 1'b1;
    repeat (6) @(posedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [47:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(i < 48 ? f[47-i] : 1'b0);
  endtask

  task automatic do_latch();
    slatch = 1'b1;
    repeat (6) @(posedge clk);
    slatch = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_digits(input string name, input logic [23:0] d, input logic [5:0] e);
`ifdef SERIAL_7SEG_RX_DECODE_EN
    chk({name, "_digits"}, dig, d);
    chk({name, "_derr"}, derr, e);
`else
    chk({name, "_digits"}, dig, 24'hFFFFFF);
    chk({name, "_derr"}, derr, 6'd0);
`endif
  endtask

  initial begin
    int s0, e0, n0;
    logic [47:0] fa, fb;
    logic [23:0] d_exp;
    fa = 48'h065BCF666D7D;
    fb = 48'h3F4F667F6F49;
    vecs[0] = '{48'h065BCF666D7D, 48, 1, 0, 48'h065BCF666D7D, 24'h123456, 6'b001000, 6'b000000};
    vecs[1] = '{48'h3F3F3F3F3F3F, 47, 0, 1, 48'h065BCF666D7D, 24'h123456, 6'b001000, 6'b000000};
    vecs[2] = '{48'h3F3F3F3F3F3F, 50, 0, 1, 48'h065BCF666D7D, 24'h123456, 6'b001000, 6'b000000};
    vecs[3] = '{48'h3F4F667F6F49, 48, 1, 0, 48'h3F4F667F6F49, 24'h03489E, 6'b000000, 6'b000001};
    vecs[4] = '{48'h00077D065B3F, 48, 1, 0, 48'h00077D065B3F, 24'hF76120, 6'b000000, 6'b000000};
    vecs[5] = '{48'h000000000000, 0, 0, 1, 48'h00077D065B3F, 24'hF76120, 6'b000000, 6'b000000};
    vecs[6] = '{48'h80FFBF86DBCF, 48, 1, 0, 48'h80FFBF86DBCF, 24'hF80123, 6'b111111, 6'b000000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", seg, 48'd0);
    chk("rst_dp", dp, 6'd0);
    chk("rst_digits", dig, 24'hFFFFFF);
    chk("rst_derr", derr, 6'd0);
    chk("rst_flags", {stb, ferr, busy}, 3'b000);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      s0 = stb_cnt; e0 = ferr_cnt; n0 = stb_cnt_n;
      send_bits(vecs[v].frame, vecs[v].nbits);
      do_latch();
      chk($sformatf("v%0d_stb", v), stb_cnt - s0, vecs[v].stb);
      chk($sformatf("v%0d_ferr", v), ferr_cnt - e0, vecs[v].err);
      chk($sformatf("v%0d_seg", v), seg, vecs[v].seg);
      chk($sformatf("v%0d_dp", v), dp, vecs[v].dp);
      chk($sformatf("v%0d_busy", v), busy, 1'b0);
      chk_digits($sformatf("v%0d", v), vecs[v].dig, vecs[v].derr);
      chk($sformatf("v%0d_inv_seg", v), seg_n, vecs[v].seg);
      chk($sformatf("v%0d_inv_stb", v), stb_cnt_n - n0, vecs[v].stb);
`ifdef SERIAL_7SEG_RX_DECODE_EN
      d_exp = vecs[v].dig;
`else
      d_exp = 24'hFFFFFF;
`endif
      chk($sformatf("v%0d_inv_digits", v), dig_n, d_exp);
    end

    s0 = stb_cnt; e0 = ferr_cnt;
    send_bits({fa[47:24], 24'h0}, 24);
    en = 1'b0;
    send_bits(48'hFF0000000000, 8);
    chk("en_busy_held", busy, 1'b1);
    en = 1'b1;
    send_bits({fa[23:0], 24'h0}, 24);
    do_latch();
    chk("en_stb", stb_cnt - s0, 1);
    chk("en_ferr", ferr_cnt - e0, 0);
    chk("en_seg", seg, fa);
    chk_digits("en", 24'h123456, 6'd0);

    s0 = stb_cnt; e0 = ferr_cnt;
    send_bits(fb, 47);
    sdata = fb[0];
    repeat (6) @(posedge clk);
    sclk = 1'b1;
    slatch = 1'b1;
    repeat (6) @(posedge clk);
    sclk = 1'b0;
    slatch = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("coinc_stb", stb_cnt - s0, 1);
    chk("coinc_ferr", ferr_cnt - e0, 0);
    chk("coinc_seg", seg, fb);
    chk_digits("coinc", 24'h03489E, 6'b000001);

    send_bits(fa, 20);
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg, 48'd0);
    chk("mid_rst_dp", dp, 6'd0);
    chk("mid_rst_digits", dig, 24'hFFFFFF);
    chk("mid_rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    s0 = stb_cnt; e0 = ferr_cnt;
    send_bits(fa, 48);
    do_latch();
    chk("post_rst_stb", stb_cnt - s0, 1);
    chk("post_rst_ferr", ferr_cnt - e0, 0);
    chk("post_rst_seg", seg, fa);
    chk("post_rst_dp", dp, 6'b001000);
    chk_digits("post_rst", 24'h123456, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
